// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in, serial-out transmitter.
// Holds the FSM state encoding and the bit-counter width calculation.
package piso_pkg;

  typedef logic [0:0] state_t;

  localparam state_t IDLE  = 1'b0;
  localparam state_t SHIFT = 1'b1;

  // The counter only has to reach WIDTH-1, but always keep at least one bit.
  function automatic int cntWidth(input int width);
    int w;
    w = $clog2(width);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Down-counter that tracks the bits left in a frame.
// Supports a synchronous load of WIDTH-1, decrement on enable, and a zero flag.
module piso_bit_counter #(
  parameter int WIDTH = 4,
  parameter int CW    = 2
) (
  input  logic Clk,
  input  logic reset,
  input  logic load_i,
  input  logic dec_i,
  output logic zero_o
);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i)
      count_d = CW'(WIDTH - 1);
    else if (dec_i)
      count_d = count_q - 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (reset)
      count_q <= '0;
    else
      count_q <= count_d;
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/piso_shift_transmitter.sv
// Parallel-in, serial-out transmitter: captures a word on load/ready and
// shifts it out one bit per shift_en tick, framed by sout_valid and done.
module piso_shift_transmitter
  import piso_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] D,
  input  logic             load,
  input  logic             shift_en,
  output logic             ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             first_bit,
  output logic             done
);

  localparam int CntW = cntWidth(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] shifted;
  logic             firstBit_q, firstBit_d;
  logic             done_q, done_d;
  logic             cntLoad, cntDec, cntZero;

  piso_bit_counter #(
    .WIDTH (WIDTH),
    .CW    (CntW)
  ) u_bit_counter (
    .Clk    (Clk),
    .reset  (reset),
    .load_i (cntLoad),
    .dec_i  (cntDec),
    .zero_o (cntZero)
  );

  // Move the register toward whichever end feeds sout, zero-filling behind.
  always_comb begin
    if (MSB_FIRST)
      shifted = {shreg_q[WIDTH-2:0], 1'b0};
    else
      shifted = {1'b0, shreg_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    firstBit_d = firstBit_q;
    done_d     = 1'b0;
    cntLoad    = 1'b0;
    cntDec     = 1'b0;
    if (state_q == IDLE) begin
      if (load) begin
        state_d    = SHIFT;
        shreg_d    = D;
        firstBit_d = 1'b1;
        cntLoad    = 1'b1;
      end
    end else if (shift_en) begin
      firstBit_d = 1'b0;
      if (cntZero) begin
        state_d = IDLE;
        shreg_d = '0;
        done_d  = 1'b1;
      end else begin
        shreg_d = shifted;
        cntDec  = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      firstBit_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      firstBit_q <= firstBit_d;
      done_q     <= done_d;
    end
  end

  assign ready      = (state_q == IDLE);
  assign sout_valid = (state_q == SHIFT);
  assign sout       = (state_q == SHIFT) &&
                      (MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0]);
  assign first_bit  = firstBit_q;
  assign done       = done_q;

endmodule

// File: doc/piso_shift_transmitter.md
Name: piso_shift_transmitter

Overview:
- Parallel-in, serial-out transmitter for the shift-register lab datapath.
- Accepts a WIDTH-bit word on a load/ready handshake and emits it one bit per shift_en tick on sout, framed by sout_valid and a done pulse.
- Counterpart to the parallel-load register stage: it drives the serial link that the serial-in/parallel-out receiver reassembles.

Parameters:
- WIDTH, 4, data word width in bits; minimum 2.
- MSB_FIRST, 1, 1 = transmit D[WIDTH-1] first; 0 = transmit D[0] first.

Ports:
- Clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- D  input  WIDTH  parallel word to transmit.
- load  input  1  request to capture D; honoured only when ready=1.
- shift_en  input  1  bit-rate tick; advances one bit when high during SHIFT.
- ready  output  1  high in IDLE; a load is accepted this cycle.
- sout  output  1  current serial bit; 0 when not transmitting.
- sout_valid  output  1  high while sout carries a data bit.
- first_bit  output  1  high while sout carries bit 0 of the frame.
- done  output  1  one-cycle pulse after the final bit is consumed.

Behaviour:
- Clock is Clk; reset is synchronous and active-high on reset.
- All state changes occur on posedge Clk.
- Reset effects (next edge): state=IDLE, shift register=0, bit counter=0, sout=0, sout_valid=0, first_bit=0, done=0.
- ready is decoded from state==IDLE, so it reads 1 in the first cycle after reset.
- Reset mid-frame aborts the frame immediately; no done pulse is issued.
- States:
  - IDLE: ready=1, sout_valid=0, sout=0. load=1 at edge k captures D into the shift register, sets bit counter=WIDTH-1, and moves to SHIFT.
  - SHIFT: ready=0, sout_valid=1. sout = shreg[WIDTH-1] if MSB_FIRST, else shreg[0]. first_bit=1 until the first accepted shift_en.
- Shift rules in SHIFT:
  - shift_en=1 and counter!=0: shift the register one place toward the output end, zero-fill, decrement the counter.
  - shift_en=1 and counter==0: go to IDLE and assert done for exactly one cycle, coincident with ready=1.
  - shift_en=0: hold all state.
- Latency: load at edge k puts the first bit on sout with sout_valid=1 from cycle k+1. A frame occupies exactly WIDTH accepted shift_en ticks.
- shift_en is ignored in IDLE, including during the load cycle.
- load while ready=0 is ignored; D is not re-sampled mid-frame.
- Back-to-back frames: load asserted in the done cycle (IDLE, ready=1) is accepted. The gap between frames is therefore one IDLE cycle.
- reset has priority over load and shift_en in every state.
- Counter width is clog2(WIDTH). Counter arithmetic never wraps, because exit happens at 0.
- All outputs are registered or decoded from registered state only; no combinational path from inputs to outputs.

Decomposition:
- Shared package piso_pkg holds:
  - state typedef (IDLE=1'b0, SHIFT=1'b1);
  - a function computing counter width from WIDTH.
- One sub-module, piso_bit_counter: a down-counter with synchronous reset, synchronous load of WIDTH-1, decrement-on-enable, and a zero flag.
- The top level instantiates piso_bit_counter and implements the FSM and shift register.

Test Plan:
- Reset check: hold reset 2 cycles with load=1, D=4'hF -> ready=1, sout=0, sout_valid=0, done=0 after release; no capture.
- MSB-first frame: WIDTH=4, MSB_FIRST=1, load D=4'b1011 with shift_en=1 continuously -> sout sequence 1,0,1,1 on cycles k+1..k+4, first_bit only at k+1, done at k+5.
- LSB-first with gaps: MSB_FIRST=0, D=4'b1011, shift_en every third cycle -> sout holds each bit until its tick, sequence 1,1,0,1; done one cycle after the 4th tick; sout_valid stays 1 throughout.
- Busy load ignored: during a frame of 4'b0110, assert load with D=4'b1111 -> serial output stays 0,1,1,0 and ready=0 until done.
- Back-to-back frames: load 4'b1000 then load 4'b0001 in the done cycle -> second frame starts the next cycle; output 1,0,0,0,0,0,0,1 with a one-cycle sout_valid gap.
- Reset mid-frame: assert reset after 2 bits of 4'b1100 -> next cycle sout_valid=0, ready=1, no done pulse; a fresh load of 4'b0101 then transmits correctly.
